// File: rtl/seq_alu.sv
// +-----------------------------------------------------------------------+
// | seq_alu: handshaked ALU, single-cycle logic ops plus bit-serial       |
// | multiply/divide sharing one 2*XLEN shift register.                     |
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
`default_nettype none

module seq_alu #(
  parameter int XLEN      = 32,
  parameter bit EN_MULDIV = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  input  logic [4:0]      ALUOp,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] Result,
  output logic            Zero,
  output logic            negative
);

  localparam int SHW = $clog2(XLEN);
  localparam logic [SHW-1:0] LAST = SHW'(XLEN - 1);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  localparam logic [4:0] OP_AND  = 5'b00000, OP_OR   = 5'b00001, OP_ADD  = 5'b00010,
                         OP_SLTU = 5'b00011, OP_SUB  = 5'b00110, OP_SLT  = 5'b00111,
                         OP_SLL  = 5'b01000, OP_SRL  = 5'b01001, OP_SRA  = 5'b01010,
                         OP_XOR  = 5'b01100, OP_DIV  = 5'b10100, OP_DIVU = 5'b10101,
                         OP_REM  = 5'b10110, OP_REMU = 5'b10111;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} state_e;

  state_e            state_q;
  logic [SHW-1:0]    cnt_q;
  logic [2*XLEN-1:0] p_q, p_d, p_neg;
  logic [XLEN-1:0]   mcand_q;
  logic              neg_q;
  logic [2:0]        op_q;
  logic              out_valid_q, zero_q, negative_q;
  logic [XLEN-1:0]   result_q;

  logic [XLEN-1:0]   fast_res, md_res, a_mag, b_mag, q_fix, r_fix;
  logic              is_md, is_div, div0, ovf, multi, accept;
  logic              a_sgn, b_sgn, a_neg, b_neg, neg_init;
  logic [XLEN:0]     mul_sum, div_sh, div_diff;

  assign in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
  assign accept    = in_valid && in_ready && !flush;
  assign out_valid = out_valid_q;
  assign Result    = result_q;
  assign Zero      = zero_q;
  assign negative  = negative_q;

  // Divide-by-zero and signed overflow resolve in one cycle; only true mul/div iterate.
  assign is_md  = EN_MULDIV && (ALUOp[4:3] == 2'b10);
  assign is_div = ALUOp[2];
  assign div0   = (B == '0);
  assign ovf    = !ALUOp[0] && (A == MOST_NEG) && (B == '1);
  assign multi  = is_md && !(is_div && (div0 || ovf));

  assign a_sgn    = is_div ? !ALUOp[0] : ((ALUOp[1:0] == 2'b01) || (ALUOp[1:0] == 2'b10));
  assign b_sgn    = is_div ? !ALUOp[0] : (ALUOp[1:0] == 2'b01);
  assign a_neg    = a_sgn && A[XLEN-1];
  assign b_neg    = b_sgn && B[XLEN-1];
  assign a_mag    = a_neg ? -A : A;
  assign b_mag    = b_neg ? -B : B;
  assign neg_init = (is_div && ALUOp[1]) ? a_neg : (a_neg ^ b_neg);

  always_comb begin
    fast_res = '0;
    case (ALUOp)
      OP_AND:  fast_res = A & B;
      OP_OR:   fast_res = A | B;
      OP_XOR:  fast_res = A ^ B;
      OP_ADD:  fast_res = A + B;
      OP_SUB:  fast_res = A - B;
      OP_SLTU: fast_res = {{(XLEN-1){1'b0}}, (A < B)};
      OP_SLT:  fast_res = {{(XLEN-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_SLL:  fast_res = A << B[SHW-1:0];
      OP_SRL:  fast_res = A >> B[SHW-1:0];
      OP_SRA:  fast_res = $unsigned($signed(A) >>> B[SHW-1:0]);
      OP_DIV, OP_DIVU: if (EN_MULDIV) fast_res = div0 ? '1 : A;
      OP_REM, OP_REMU: if (EN_MULDIV) fast_res = div0 ? A : '0;
      default: fast_res = '0;
    endcase
  end

  // Multiply: shift-add on {hi, multiplier}. Divide: restoring on {remainder, dividend}.
  always_comb begin
    mul_sum  = {1'b0, p_q[2*XLEN-1:XLEN]} + (p_q[0] ? {1'b0, mcand_q} : '0);
    div_sh   = {p_q[2*XLEN-1:XLEN], p_q[XLEN-1]};
    div_diff = div_sh - {1'b0, mcand_q};
    if (!op_q[2])
      p_d = {mul_sum, p_q[XLEN-1:1]};
    else if (div_diff[XLEN])
      p_d = {div_sh[XLEN-1:0], p_q[XLEN-2:0], 1'b0};
    else
      p_d = {div_diff[XLEN-1:0], p_q[XLEN-2:0], 1'b1};
    p_neg = neg_q ? -p_d : p_d;
    q_fix = neg_q ? -p_d[XLEN-1:0] : p_d[XLEN-1:0];
    r_fix = neg_q ? -p_d[2*XLEN-1:XLEN] : p_d[2*XLEN-1:XLEN];
    if (op_q[2])
      md_res = op_q[1] ? r_fix : q_fix;
    else
      md_res = (op_q[1:0] == 2'b00) ? p_neg[XLEN-1:0] : p_neg[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      p_q         <= '0;
      mcand_q     <= '0;
      neg_q       <= 1'b0;
      op_q        <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      negative_q  <= 1'b0;
    end else if (flush) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
    end else if (accept) begin
      if (multi) begin
        state_q     <= S_BUSY;
        out_valid_q <= 1'b0;
        cnt_q       <= '0;
        p_q         <= {{XLEN{1'b0}}, a_mag};
        mcand_q     <= b_mag;
        neg_q       <= neg_init;
        op_q        <= ALUOp[2:0];
      end else begin
        state_q     <= S_DONE;
        out_valid_q <= 1'b1;
        result_q    <= fast_res;
        zero_q      <= (fast_res == '0);
        negative_q  <= fast_res[XLEN-1];
      end
    end else begin
      case (state_q)
        S_BUSY: begin
          p_q   <= p_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_q     <= S_DONE;
            out_valid_q <= 1'b1;
            result_q    <= md_res;
            zero_q      <= (md_res == '0);
            negative_q  <= md_res[XLEN-1];
          end
        end
        S_DONE: if (out_ready) begin
          state_q     <= S_IDLE;
          out_valid_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter XLEN, default 32, SHALL set the operand and result width; legal values are 8, 16, 32 and 64.
REQ-002 Parameter EN_MULDIV, default 1, SHALL enable the multiply/divide opcodes; when 0, those opcodes SHALL behave as undefined opcodes.
REQ-003 Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  SHALL be the reset, asynchronous and active-high.
REQ-005 Port in_valid  input  1  SHALL mark a valid request.
REQ-006 Port in_ready  output  1  SHALL mark that a request can be accepted.
REQ-007 Port A  input  XLEN  SHALL be operand A.
REQ-008 Port B  input  XLEN  SHALL be operand B; shifts use B[$clog2(XLEN)-1:0].
REQ-009 Port ALUOp  input  5  SHALL be the opcode.
REQ-010 Port flush  input  1  SHALL abort any in-flight or pending result synchronously.
REQ-011 Port out_valid  output  1  SHALL mark a valid registered result.
REQ-012 Port out_ready  input  1  SHALL mark that the consumer takes the result.
REQ-013 Port Result  output  XLEN  SHALL be the registered result.
REQ-014 Port Zero  output  1  SHALL be 1 when Result is 0.
REQ-015 Port negative  output  1  SHALL equal Result[XLEN-1].

Function
REQ-016 Opcodes SHALL be: AND 00000, OR 00001, ADD 00010, SLTU 00011, SUB 00110, SLT 00111, SLL 01000, SRL 01001, SRA 01010, XOR 01100, MUL 10000, MULH 10001, MULHSU 10010, MULHU 10011, DIV 10100, DIVU 10101, REM 10110, REMU 10111.
REQ-017 Any other opcode SHALL produce Result 0 with single-cycle latency.
REQ-018 A request SHALL be accepted in a cycle where in_valid and in_ready are both 1; operands and opcode are captured at acceptance.
REQ-019 The FSM SHALL have states IDLE, BUSY and DONE, with in_ready = (IDLE) or (DONE and out_ready).
REQ-020 Single-cycle ops SHALL be accepted in cycle N and move the FSM to DONE with out_valid = 1 in cycle N+1.
REQ-021 MUL*/DIV*/REM* ops SHALL be computed iteratively (one bit per cycle): BUSY for XLEN cycles, then DONE with out_valid = 1 in cycle N+XLEN+1.
REQ-022 MUL SHALL return the low XLEN bits of the product; MULH, MULHSU and MULHU SHALL return the high XLEN bits as signed x signed, signed x unsigned and unsigned x unsigned respectively.
REQ-023 Divide by zero SHALL take the single-cycle path: DIV/DIVU give all ones, REM/REMU give A.
REQ-024 Signed overflow (A = most-negative, B = -1) SHALL take the single-cycle path: DIV gives A, REM gives 0.
REQ-025 Signed division SHALL truncate toward zero; the remainder takes the sign of the dividend.
REQ-026 While out_valid = 1 and out_ready = 0, Result, Zero and negative SHALL be held stable and in_ready SHALL be 0.
REQ-027 On DONE with out_ready = 1: if a new request is accepted in the same cycle, the FSM SHALL follow REQ-020/021; otherwise it SHALL return to IDLE and out_valid SHALL drop.
REQ-028 in_valid during BUSY SHALL be ignored (in_ready = 0).
REQ-029 flush = 1 SHALL force the FSM to IDLE and out_valid to 0 on the next edge, and SHALL override acceptance in the same cycle.
REQ-030 All arithmetic SHALL be modulo 2^XLEN; SLT and SLTU SHALL return 1 or 0 zero-extended.

Reset
REQ-031 While rst = 1, the FSM SHALL be IDLE, out_valid 0, Result 0, Zero 0 and negative 0, and the iteration counter and datapath registers SHALL be 0.
REQ-032 rst asserted mid-BUSY SHALL discard the operation; in_ready SHALL be 1 in the first cycle after rst deasserts.

Verification (XLEN = 32)
REQ-033 ADD A=5, B=7, out_ready=1 -> out_valid in the next cycle, Result 12, Zero 0, negative 0.
REQ-034 MULHU A=0xFFFFFFFF, B=2 -> Result 1 at cycle N+33; MUL with the same operands -> 0xFFFFFFFE; in_ready is 0 for 32 cycles.
REQ-035 DIV A=7, B=0 -> 0xFFFFFFFF; REM A=7, B=0 -> 7; both at latency 1. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM with the same operands -> 0.
REQ-036 SUB A=3, B=3 with out_ready=0 for 3 cycles -> Result 0, Zero 1, held for 3 cycles; in_valid during those cycles is not accepted; a back-to-back request is accepted in the cycle out_ready rises.
REQ-037 DIVU 100/7 with rst pulsed at BUSY cycle 10 -> out_valid never asserts and in_ready = 1 after release; the same test with flush instead -> identical outcome.
